// File: rtl/bsr_mmio_bridge_pkg.sv
// Shared MMIO definitions: UMEM status codes, opm bit positions, size codes and the MMIO base.
package bsr_mmio_bridge_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  localparam int OPM_WR = 4;
  localparam int OPM_OE = 3;
  localparam int OPM_ZX = 2;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_W = 2'b01;
  localparam logic [1:0] SIZE_D = 2'b10;
  localparam logic [1:0] SIZE_Q = 2'b11;

  localparam logic [15:0] MMIO_BASE = 16'hE000;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_W:  misaligned = a[0];
      SIZE_D:  misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bsr_mmio_bridge_lane.sv
// Combinational byte-lane unit: store byte-enable/data replication and load lane extract with extension.
module bsr_mmio_lane
  import bsr_mmio_bridge_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select for reads and lane placement for writes
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (addr_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    half_s = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = zext_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      SIZE_W: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = zext_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      end
      SIZE_D: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/bsr_mmio_bridge.sv
// MMIO bridge: turns the memory tile's level-held mmio request into one decoded, acked device access
// with timeout, reporting UMEM_OK status and extended read data from registers.
module bsr_mmio_bridge
  import bsr_mmio_bridge_pkg::*;
#(
  parameter int NDEV        = 4,
  parameter int DEV_SHIFT   = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     mmioAddr,
  input  logic [31:0]     mmioOutData,
  input  logic [4:0]      mmioOpm,
  output logic [31:0]     mmioInData,
  output logic [1:0]      mmioOK,
  output logic [15:0]     devAddr,
  output logic [31:0]     devWData,
  output logic [3:0]      devBe,
  output logic            devRd,
  output logic            devWr,
  output logic [NDEV-1:0] devSel,
  input  logic [31:0]     devRData,
  input  logic            devAck
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
  localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      opm_q, opm_d;
  logic [IDXW-1:0] win_q, win_d;
  logic            fault_q, fault_d;
  logic            abort_q, abort_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      ok_q, ok_d;
  logic [31:0]     rdata_q, rdata_d;

  logic        req_s, bad_s, done_s, ack_fault_s;
  logic [2:0]  win_full_s;
  logic [3:0]  lane_be_s;
  logic [31:0] lane_wdata_s, lane_rdata_s;
  logic        unused_s;

  assign req_s      = mmioOpm[OPM_WR] | mmioOpm[OPM_OE];
  assign win_full_s = mmioAddr[DEV_SHIFT+2:DEV_SHIFT];
  assign bad_s      = (mmioOpm[1:0] == SIZE_Q) | misaligned(mmioOpm[1:0], mmioAddr[1:0])
                    | ({mmioAddr[19:16], mmioAddr[15:13]} != {4'h0, MMIO_BASE[15:13]})
                    | ({1'b0, win_full_s} >= 4'(NDEV));
  assign unused_s   = ^mmioAddr[31:20];

  bsr_mmio_lane u_lane (
    .addr_i  (addr_q[1:0]),
    .size_i  (opm_q[1:0]),
    .zext_i  (opm_q[OPM_ZX]),
    .wdata_i (wdata_q),
    .rdata_i (devRData),
    .be_o    (lane_be_s),
    .wdata_o (lane_wdata_s),
    .rdata_o (lane_rdata_s)
  );

  // Transaction sequencing; status and read data are computed here and registered below
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    opm_d       = opm_q;
    win_d       = win_q;
    fault_d     = fault_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    ok_d        = req_s ? UMEM_OK_HOLD : UMEM_OK_READY;
    rdata_d     = 32'h0000_0000;
    done_s      = 1'b0;
    ack_fault_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          addr_d  = mmioAddr[15:0];
          wdata_d = mmioOutData;
          opm_d   = mmioOpm;
          win_d   = mmioAddr[DEV_SHIFT +: IDXW];
          fault_d = bad_s;
          abort_d = 1'b0;
          state_d = bad_s ? ST_DONE : ST_ISSUE;
          if (bad_s) begin
            ok_d = UMEM_OK_FAULT;
          end else begin
            ok_d = UMEM_OK_HOLD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 8'd0;
        abort_d = abort_q | ~req_s;
      end
      ST_WAIT: begin
        abort_d = abort_q | ~req_s;
        // Ack takes priority over an expiring counter in the same cycle
        if (devAck) begin
          done_s = 1'b1;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          done_s      = 1'b1;
          ack_fault_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done_s) begin
          fault_d = ack_fault_s;
          if (abort_q | ~req_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            ok_d    = ack_fault_s ? UMEM_OK_FAULT : UMEM_OK_OK;
            rdata_d = ack_fault_s ? 32'h0000_0000 : lane_rdata_s;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (req_s) begin
          ok_d    = ok_q;
          rdata_d = rdata_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 32'h0000_0000;
      opm_q   <= 5'b00000;
      win_q   <= '0;
      fault_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= 8'd0;
      ok_q    <= UMEM_OK_READY;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      opm_q   <= opm_d;
      win_q   <= win_d;
      fault_q <= fault_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
    end
  end

  assign mmioOK     = ok_q;
  assign mmioInData = rdata_q;
  assign devAddr    = addr_q;
  assign devRd      = (state_q == ST_ISSUE) & opm_q[OPM_OE] & ~opm_q[OPM_WR];
  assign devWr      = (state_q == ST_ISSUE) & opm_q[OPM_WR];
  assign devBe      = (state_q == ST_ISSUE) ? lane_be_s : 4'b0000;
  assign devWData   = (state_q == ST_ISSUE) ? lane_wdata_s : 32'h0000_0000;
  assign devSel     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? (NDEV'(1) << win_q)
                                                                      : '0;

endmodule

// File: tb/tb_bsr_mmio_bridge.sv
// Scoreboarded bench for bsr_mmio_bridge: decode, lanes, faults, timeout, abort and reset behaviour.
module tb_bsr_mmio_bridge;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mmioAddr = 32'h0, mmioOutData = 32'h0, devRData = 32'h0;
  logic [4:0]  mmioOpm = 5'b0;
  logic        devAck = 1'b0;
  logic [31:0] mmioInData, devWData;
  logic [1:0]  mmioOK;
  logic [15:0] devAddr;
  logic [3:0]  devBe, devSel;
  logic        devRd, devWr;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [33:0] sb_q[$];
  logic [33:0] exp_s;

  bsr_mmio_bridge #(.NDEV(4), .DEV_SHIFT(10), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset), .mmioAddr(mmioAddr), .mmioOutData(mmioOutData),
    .mmioOpm(mmioOpm), .mmioInData(mmioInData), .mmioOK(mmioOK), .devAddr(devAddr),
    .devWData(devWData), .devBe(devBe), .devRd(devRd), .devWr(devWr), .devSel(devSel),
    .devRData(devRData), .devAck(devAck)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (devRd) rd_cnt++;
    if (devWr) wr_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request, one ISSUE cycle, ack in the first WAIT cycle, ends in DONE
  task automatic drive_acked(input logic [31:0] a, input logic [31:0] d, input logic [4:0] opm);
    mmioAddr = a; mmioOutData = d; mmioOpm = opm;
    tick();
    devAck = 1'b1;
    tick();
    tick();
    devAck = 1'b0;
  endtask

  task automatic release_req();
    mmioOpm = 5'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (mmioOK !== 2'b00 || mmioInData !== 32'h0) begin
      errors++; $display("FAIL reset_status got %b/%h want 00/00000000", mmioOK, mmioInData);
    end
    checks++;
    if (devSel !== 4'b0 || devRd !== 1'b0 || devWr !== 1'b0 || devBe !== 4'b0 ||
        devWData !== 32'h0 || devAddr !== 16'h0) begin
      errors++; $display("FAIL reset_dev got sel=%b rd=%b wr=%b be=%b wd=%h a=%h want all 0",
                         devSel, devRd, devWr, devBe, devWData, devAddr);
    end
  endtask

  task automatic test_read_d();
    int r0;
    r0 = rd_cnt;
    devRData = 32'h1234_5678;
    sb_q.push_back({2'b01, 32'h1234_5678});
    mmioAddr = 32'hE004; mmioOpm = 5'b01010;
    tick();
    checks++;
    if (devSel !== 4'b0001 || devRd !== 1'b1 || devWr !== 1'b0 || devBe !== 4'b1111) begin
      errors++; $display("FAIL rdD_issue got sel=%b rd=%b wr=%b be=%b want 0001 1 0 1111",
                         devSel, devRd, devWr, devBe);
    end
    checks++;
    if (mmioOK !== 2'b10) begin errors++; $display("FAIL rdD_hold got %b want 10", mmioOK); end
    devAck = 1'b1;
    tick();
    checks++;
    if (devSel !== 4'b0001 || devRd !== 1'b0) begin
      errors++; $display("FAIL rdD_wait got sel=%b rd=%b want 0001 0", devSel, devRd);
    end
    tick();
    devAck = 1'b0;
    exp_s = sb_q.pop_front();
    checks++;
    if ({mmioOK, mmioInData} !== exp_s) begin
      errors++; $display("FAIL rdD_done got %h want %h", {mmioOK, mmioInData}, exp_s);
    end
    tick(); tick();
    checks++;
    if (mmioOK !== 2'b01 || mmioInData !== 32'h1234_5678 || rd_cnt - r0 != 1) begin
      errors++; $display("FAIL rdD_held got ok=%b data=%h strobes=%0d want 01 12345678 1",
                         mmioOK, mmioInData, rd_cnt - r0);
    end
    release_req();
    checks++;
    if (mmioOK !== 2'b00) begin errors++; $display("FAIL rdD_idle got %b want 00", mmioOK); end
  endtask

  task automatic test_write_b();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    devRData = 32'h0;
    sb_q.push_back({2'b01, 32'h0});
    mmioAddr = 32'hE403; mmioOutData = 32'h0000_00A5; mmioOpm = 5'b11000;
    tick();
    checks++;
    if (devSel !== 4'b0010 || devWr !== 1'b1 || devRd !== 1'b0 || devBe !== 4'b1000 ||
        devWData !== 32'hA5A5_A5A5 || devAddr !== 16'hE403) begin
      errors++; $display("FAIL wrB_issue got sel=%b wr=%b rd=%b be=%b wd=%h a=%h",
                         devSel, devWr, devRd, devBe, devWData, devAddr);
    end
    devAck = 1'b1;
    tick(); tick();
    devAck = 1'b0;
    exp_s = sb_q.pop_front();
    checks++;
    if ({mmioOK, mmioInData} !== exp_s) begin
      errors++; $display("FAIL wrB_done got %h want %h", {mmioOK, mmioInData}, exp_s);
    end
    tick(); tick(); tick();
    checks++;
    if (wr_cnt - w0 != 1 || rd_cnt != r0 || mmioOK !== 2'b01) begin
      errors++; $display("FAIL wrB_single got wr=%0d rd=%0d ok=%b want 1 0 01",
                         wr_cnt - w0, rd_cnt - r0, mmioOK);
    end
    release_req();
  endtask

  task automatic test_read_b_ext();
    devRData = 32'h0080_0000;
    sb_q.push_back({2'b01, 32'hFFFF_FF80});
    sb_q.push_back({2'b01, 32'h0000_0080});
    for (int k = 0; k < 2; k++) begin
      drive_acked(32'hE802, 32'h0, (k == 0) ? 5'b01000 : 5'b01100);
      exp_s = sb_q.pop_front();
      checks++;
      if ({mmioOK, mmioInData} !== exp_s) begin
        errors++; $display("FAIL rdB_ext%0d got %h want %h", k, {mmioOK, mmioInData}, exp_s);
      end
      release_req();
    end
  endtask

  task automatic test_faults();
    logic [31:0] fa[3];
    logic [4:0]  fo[3];
    int r0, w0;
    fa[0] = 32'hE000; fo[0] = 5'b01011;
    fa[1] = 32'hE001; fo[1] = 5'b11001;
    fa[2] = 32'hF000; fo[2] = 5'b01010;
    for (int k = 0; k < 3; k++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      sb_q.push_back({2'b11, 32'h0});
      mmioAddr = fa[k]; mmioOpm = fo[k];
      tick();
      exp_s = sb_q.pop_front();
      checks++;
      if ({mmioOK, mmioInData} !== exp_s || devSel !== 4'b0) begin
        errors++; $display("FAIL fault%0d got %h sel=%b want %h sel=0000",
                           k, {mmioOK, mmioInData}, devSel, exp_s);
      end
      tick();
      checks++;
      if (rd_cnt != r0 || wr_cnt != w0 || mmioOK !== 2'b11) begin
        errors++; $display("FAIL fault%0d_nostrobe got rd=%0d wr=%0d ok=%b want 0 0 11",
                           k, rd_cnt - r0, wr_cnt - w0, mmioOK);
      end
      release_req();
    end
  endtask

  task automatic test_timeout();
    devRData = 32'hCAFE_F00D;
    sb_q.push_back({2'b11, 32'h0});
    sb_q.push_back({2'b01, 32'hCAFE_F00D});
    for (int k = 0; k < 2; k++) begin
      mmioAddr = 32'hE008; mmioOpm = 5'b01010;
      tick();
      tick();
      for (int n = 1; n < TMO; n++) tick();
      checks++;
      if (mmioOK !== 2'b10) begin
        errors++; $display("FAIL tmo%0d_early got %b want 10", k, mmioOK);
      end
      if (k == 1) devAck = 1'b1;
      tick();
      devAck = 1'b0;
      exp_s = sb_q.pop_front();
      checks++;
      if ({mmioOK, mmioInData} !== exp_s) begin
        errors++; $display("FAIL tmo%0d_end got %h want %h", k, {mmioOK, mmioInData}, exp_s);
      end
      release_req();
    end
  endtask

  task automatic test_abort();
    int seen_ok;
    seen_ok = 0;
    mmioAddr = 32'hE004; mmioOpm = 5'b01010;
    tick(); tick();
    mmioOpm = 5'b0;
    tick();
    if (mmioOK === 2'b01) seen_ok++;
    devAck = 1'b1;
    tick();
    devAck = 1'b0;
    if (mmioOK === 2'b01) seen_ok++;
    tick();
    if (mmioOK === 2'b01) seen_ok++;
    checks++;
    if (seen_ok != 0 || mmioOK !== 2'b00 || devSel !== 4'b0) begin
      errors++; $display("FAIL abort got ok_seen=%0d ok=%b sel=%b want 0 00 0000",
                         seen_ok, mmioOK, devSel);
    end
  endtask

  task automatic test_reset_mid();
    mmioAddr = 32'hE404; mmioOpm = 5'b01010;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (devSel !== 4'b0 || mmioOK !== 2'b00 || devRd !== 1'b0) begin
      errors++; $display("FAIL rst_mid got sel=%b ok=%b rd=%b want 0000 00 0", devSel, mmioOK, devRd);
    end
    mmioOpm = 5'b0;
    #1 reset = 1'b1;
    tick();
    checks++;
    if (mmioOK !== 2'b00 || devSel !== 4'b0) begin
      errors++; $display("FAIL rst_after got ok=%b sel=%b want 00 0000", mmioOK, devSel);
    end
  endtask

  task automatic test_back_to_back();
    sb_q.push_back({2'b01, 32'h0000_BEEF});
    sb_q.push_back({2'b01, 32'h0});
    sb_q.push_back({2'b01, 32'hFFFF_8001});
    devRData = 32'hBEEF_1234;
    mmioAddr = 32'hEC02; mmioOpm = 5'b01101;
    tick();
    checks++;
    if (devSel !== 4'b1000 || devBe !== 4'b1100) begin
      errors++; $display("FAIL b2b_w_issue got sel=%b be=%b want 1000 1100", devSel, devBe);
    end
    devAck = 1'b1; tick(); tick(); devAck = 1'b0;
    exp_s = sb_q.pop_front();
    checks++;
    if ({mmioOK, mmioInData} !== exp_s) begin
      errors++; $display("FAIL b2b_w got %h want %h", {mmioOK, mmioInData}, exp_s);
    end
    release_req();
    devRData = 32'h0;
    mmioAddr = 32'hEC04; mmioOutData = 32'h1122_3344; mmioOpm = 5'b10010;
    tick();
    checks++;
    if (devSel !== 4'b1000 || devWr !== 1'b1 || devBe !== 4'b1111 || devWData !== 32'h1122_3344) begin
      errors++; $display("FAIL b2b_d_issue got sel=%b wr=%b be=%b wd=%h", devSel, devWr, devBe, devWData);
    end
    devAck = 1'b1; tick(); tick(); devAck = 1'b0;
    exp_s = sb_q.pop_front();
    checks++;
    if ({mmioOK, mmioInData} !== exp_s) begin
      errors++; $display("FAIL b2b_d got %h want %h", {mmioOK, mmioInData}, exp_s);
    end
    release_req();
    devRData = 32'h8001_7FFF;
    drive_acked(32'hE006, 32'h0, 5'b01001);
    exp_s = sb_q.pop_front();
    checks++;
    if ({mmioOK, mmioInData} !== exp_s) begin
      errors++; $display("FAIL b2b_ws got %h want %h", {mmioOK, mmioInData}, exp_s);
    end
    release_req();
  endtask

  initial begin
    tick(); tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_read_d();
    test_write_b();
    test_read_b_ext();
    test_faults();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
